// File: rtl/sprite_line_evaluator.sv
// Per-scanline sprite evaluator. It clears the secondary buffer, scans primary OAM for sprites
// on yPosition, copies up to MAX_PER_LINE entries and then looks for overflow (optionally with byte drift).
module sprite_line_evaluator #(
  parameter int NUM_OAM      = 64,
  parameter int MAX_PER_LINE = 8,
  parameter bit OVERFLOW_BUG = 1'b1,
  localparam int AW = $clog2(NUM_OAM * 4),
  localparam int SW = $clog2(MAX_PER_LINE * 4),
  localparam int CW = $clog2(MAX_PER_LINE + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clock_EN,
  input  logic          eval_start,
  input  logic          tallSprites,
  input  logic [8:0]    yPosition,
  output logic [AW-1:0] oamAddr,
  input  logic [7:0]    oamData,
  input  logic [SW-1:0] secRdIndex,
  output logic [7:0]    secRdData,
  output logic [CW-1:0] spriteCount,
  output logic          spriteZeroOnLine,
  output logic          spriteOverflow,
  input  logic          resetFlags,
  output logic          busy,
  output logic          done,
  output logic [1:0]    dbg_state_o
);

  localparam int NW     = AW - 2;
  localparam int SDEPTH = 2 ** SW;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CLEAR = 2'd1, S_SCAN = 2'd2, S_DONE = 2'd3} state_t;

  state_t        state_q;
  logic [SW-1:0] clr_q;
  logic [NW-1:0] n_q;
  logic [1:0]    m_q;
  logic          ph_q;
  logic [CW-1:0] cnt_q;
  logic          zero_q;
  logic          ovf_q;
  logic          tall_q;
  logic [8:0]    ypos_q;
  logic [7:0]    sec_q [SDEPTH];

  logic [9:0]    diff;
  logic          in_range;
  logic          full;
  logic          last_n;
  logic [CW+1:0] slot_idx;
  logic          wr_en;
  logic [SW-1:0] wr_addr;
  logic [7:0]    wr_data;

  always_comb begin
    diff     = {1'b0, ypos_q} - {2'b00, oamData};
    in_range = ~diff[9] && (diff[8:0] < (tall_q ? 9'd16 : 9'd8));
    full     = (cnt_q == CW'(MAX_PER_LINE));
    last_n   = (n_q == NW'(NUM_OAM - 1));
    slot_idx = {cnt_q, m_q};
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = 8'hFF;
    // Writes are suppressed on reset or restart so an aborted pass leaves no stray bytes.
    if (clock_EN && !reset && !eval_start) begin
      if (state_q == S_CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = clr_q;
      end else if (state_q == S_SCAN && ph_q && !full && (m_q != 2'd0 || in_range)) begin
        wr_en   = 1'b1;
        wr_addr = slot_idx[SW-1:0];
        wr_data = oamData;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) sec_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      clr_q   <= '0;
      n_q     <= '0;
      m_q     <= 2'd0;
      ph_q    <= 1'b0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      tall_q  <= 1'b0;
      ypos_q  <= '0;
    end else if (clock_EN) begin
      if (eval_start) begin
        state_q <= S_CLEAR;
        clr_q   <= '0;
        n_q     <= '0;
        m_q     <= 2'd0;
        ph_q    <= 1'b0;
        cnt_q   <= '0;
        zero_q  <= 1'b0;
        tall_q  <= tallSprites;
        ypos_q  <= yPosition;
      end else begin
        case (state_q)
          S_CLEAR: begin
            if (clr_q == SW'(MAX_PER_LINE * 4 - 1)) begin
              state_q <= S_SCAN;
              clr_q   <= '0;
            end else begin
              clr_q <= clr_q + 1'b1;
            end
          end
          S_SCAN: begin
            ph_q <= ~ph_q;
            if (ph_q) begin
              if (!full) begin
                if (m_q == 2'd0 && !in_range) begin
                  n_q <= n_q + 1'b1;
                  if (last_n) state_q <= S_DONE;
                end else if (m_q == 2'd3) begin
                  cnt_q <= cnt_q + 1'b1;
                  if (n_q == '0) zero_q <= 1'b1;
                  m_q <= 2'd0;
                  n_q <= n_q + 1'b1;
                  if (last_n) state_q <= S_DONE;
                end else begin
                  m_q <= m_q + 2'd1;
                end
              end else if (in_range) begin
                ovf_q   <= 1'b1;
                state_q <= S_DONE;
              end else begin
                // Hardware-faithful mode lets the byte index drift along with n.
                m_q <= OVERFLOW_BUG ? m_q + 2'd1 : 2'd0;
                n_q <= n_q + 1'b1;
                if (last_n) state_q <= S_DONE;
              end
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
      if (resetFlags) ovf_q <= 1'b0;
    end
  end

  assign oamAddr          = (state_q == S_SCAN) ? {n_q, m_q} : '0;
  assign secRdData        = sec_q[secRdIndex];
  assign spriteCount      = cnt_q;
  assign spriteZeroOnLine = zero_q;
  assign spriteOverflow   = ovf_q;
  assign busy             = (state_q == S_CLEAR) || (state_q == S_SCAN);
  assign done             = (state_q == S_DONE);
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_sprite_line_evaluator.sv
// Table-driven bench for sprite_line_evaluator: three instances (default, exact-overflow, large)
// each with its own synchronous OAM model; hand sequences cover restart, reset, enable stalls.
module tb_sprite_line_evaluator;

  logic       clk = 1'b0;
  logic       reset, clock_EN, tall, resetFlags;
  logic [8:0] ypos;
  logic [2:0] eval_start;
  logic [5:0] rd_idx;

  logic [7:0] addr0, addr1, sec0, sec1, sec2, rd0, rd1, rd2;
  logic [8:0] addr2;
  logic [3:0] cnt0, cnt1;
  logic [4:0] cnt2;
  logic       z0, z1, z2, ov0, ov1, ov2, busy0, busy1, busy2, done0, done1, done2;
  logic [1:0] st0, st1, st2;

  logic [7:0] oam0 [0:255];
  logic [7:0] oam1 [0:255];
  logic [7:0] oam2 [0:511];

  int n_chk = 0;
  int n_fail = 0;
  int cyc;

  always #5 clk = ~clk;

  sprite_line_evaluator #(.NUM_OAM(64), .MAX_PER_LINE(8), .OVERFLOW_BUG(1'b1)) dut0 (
    .clock(clk), .reset(reset), .clock_EN(clock_EN), .eval_start(eval_start[0]),
    .tallSprites(tall), .yPosition(ypos), .oamAddr(addr0), .oamData(rd0),
    .secRdIndex(rd_idx[4:0]), .secRdData(sec0), .spriteCount(cnt0), .spriteZeroOnLine(z0),
    .spriteOverflow(ov0), .resetFlags(resetFlags), .busy(busy0), .done(done0), .dbg_state_o(st0));

  sprite_line_evaluator #(.NUM_OAM(64), .MAX_PER_LINE(8), .OVERFLOW_BUG(1'b0)) dut1 (
    .clock(clk), .reset(reset), .clock_EN(clock_EN), .eval_start(eval_start[1]),
    .tallSprites(tall), .yPosition(ypos), .oamAddr(addr1), .oamData(rd1),
    .secRdIndex(rd_idx[4:0]), .secRdData(sec1), .spriteCount(cnt1), .spriteZeroOnLine(z1),
    .spriteOverflow(ov1), .resetFlags(resetFlags), .busy(busy1), .done(done1), .dbg_state_o(st1));

  sprite_line_evaluator #(.NUM_OAM(128), .MAX_PER_LINE(16), .OVERFLOW_BUG(1'b1)) dut2 (
    .clock(clk), .reset(reset), .clock_EN(clock_EN), .eval_start(eval_start[2]),
    .tallSprites(tall), .yPosition(ypos), .oamAddr(addr2), .oamData(rd2),
    .secRdIndex(rd_idx), .secRdData(sec2), .spriteCount(cnt2), .spriteZeroOnLine(z2),
    .spriteOverflow(ov2), .resetFlags(resetFlags), .busy(busy2), .done(done2), .dbg_state_o(st2));

  // OAM models: data appears on the enabled cycle after the address.
  always @(posedge clk) begin
    if (clock_EN) begin
      rd0 <= oam0[addr0];
      rd1 <= oam1[addr1];
      rd2 <= oam2[addr2];
    end
  end

  function automatic int get_done(int s);
    case (s) 0: return int'(done0); 1: return int'(done1); default: return int'(done2); endcase
  endfunction
  function automatic int get_busy(int s);
    case (s) 0: return int'(busy0); 1: return int'(busy1); default: return int'(busy2); endcase
  endfunction
  function automatic int get_cnt(int s);
    case (s) 0: return int'(cnt0); 1: return int'(cnt1); default: return int'(cnt2); endcase
  endfunction
  function automatic int get_zero(int s);
    case (s) 0: return int'(z0); 1: return int'(z1); default: return int'(z2); endcase
  endfunction
  function automatic int get_ovf(int s);
    case (s) 0: return int'(ov0); 1: return int'(ov1); default: return int'(ov2); endcase
  endfunction
  function automatic int get_state(int s);
    case (s) 0: return int'(st0); 1: return int'(st1); default: return int'(st2); endcase
  endfunction
  function automatic int get_addr(int s);
    case (s) 0: return int'(addr0); 1: return int'(addr1); default: return int'(addr2); endcase
  endfunction
  function automatic int get_sec(int s);
    case (s) 0: return int'(sec0); 1: return int'(sec1); default: return int'(sec2); endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_byte(input int s, input int idx, input logic [7:0] val);
    case (s)
      0: if (idx < 256) oam0[idx] = val;
      1: if (idx < 256) oam1[idx] = val;
      default: oam2[idx] = val;
    endcase
  endtask

  task automatic set_entry(input int s, input int e, input logic [7:0] y, input logic [7:0] t,
                           input logic [7:0] a, input logic [7:0] x);
    set_byte(s, 4*e, y); set_byte(s, 4*e+1, t); set_byte(s, 4*e+2, a); set_byte(s, 4*e+3, x);
  endtask

  task automatic load_scen(input int sc, input int s);
    for (int i = 0; i < 512; i++) set_byte(s, i, 8'hFF);
    case (sc)
      1: set_entry(s, 0, 8'd50, 8'h12, 8'h41, 8'h80);
      2: for (int i = 0; i < 9; i++) set_entry(s, i, 8'd10, 8'(i), 8'h00, 8'(i));
      3: begin
        for (int i = 0; i < 8; i++) set_entry(s, i, 8'd10, 8'(i), 8'h00, 8'(i));
        set_byte(s, 33, 8'd10);
        set_byte(s, 37, 8'd12);
      end
      4: for (int i = 0; i < 20; i++) set_entry(s, i, 8'd10, 8'(i), 8'h00, 8'(8'hA0 + i));
      5: set_entry(s, 3, 8'd50, 8'h01, 8'h02, 8'h03);
      6: set_entry(s, 0, 8'hEF, 8'h05, 8'h06, 8'h07);
      default: ;
    endcase
  endtask

  task automatic wait_done(input int s, input int start, output int c);
    c = start;
    while (get_done(s) == 0 && c < 3000) begin
      tick();
      c++;
    end
    chk($sformatf("done_seen_dut%0d", s), get_done(s), 1);
  endtask

  // c counts enabled edges from the eval_start edge (counted as 1) to the edge raising done.
  task automatic run_eval(input int s, output int c);
    eval_start[s] = 1'b1;
    tick();
    eval_start = '0;
    wait_done(s, 1, c);
  endtask

  typedef struct {
    int sc; int sel; logic tl; int yp; int cnt; int zero; int ovf; int cyc; int bufk;
  } vec_t;
  localparam int NV = 13;
  vec_t vecs [NV];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0, 0, 1'b0, 100, 0,  0, 0, 161, 2};
    vecs[1]  = '{1, 0, 1'b0, 57,  1,  1, 0, 167, 1};
    vecs[2]  = '{1, 0, 1'b0, 58,  0,  0, 0, 161, 0};
    vecs[3]  = '{1, 0, 1'b1, 58,  1,  1, 0, 167, 0};
    vecs[4]  = '{2, 0, 1'b0, 12,  8,  1, 1, 99,  0};
    vecs[5]  = '{3, 1, 1'b0, 12,  8,  1, 0, 209, 0};
    vecs[6]  = '{3, 0, 1'b0, 12,  8,  1, 1, 101, 0};
    vecs[7]  = '{2, 1, 1'b0, 12,  8,  1, 1, 99,  0};
    vecs[8]  = '{4, 2, 1'b0, 12,  16, 1, 1, 195, 3};
    vecs[9]  = '{5, 0, 1'b0, 57,  1,  0, 0, 167, 0};
    vecs[10] = '{1, 0, 1'b0, 50,  1,  1, 0, 167, 0};
    vecs[11] = '{1, 0, 1'b0, 49,  0,  0, 0, 161, 0};
    vecs[12] = '{6, 0, 1'b0, 240, 1,  1, 0, 167, 0};

    reset = 1'b1; clock_EN = 1'b1; tall = 1'b0; resetFlags = 1'b0;
    ypos = '0; eval_start = '0; rd_idx = '0;
    for (int s = 0; s < 3; s++) load_scen(0, s);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    for (int s = 0; s < 3; s += 2) begin
      chk($sformatf("rst_state_dut%0d", s), get_state(s), 0);
      chk($sformatf("rst_busy_dut%0d", s), get_busy(s), 0);
      chk($sformatf("rst_done_dut%0d", s), get_done(s), 0);
      chk($sformatf("rst_cnt_dut%0d", s), get_cnt(s), 0);
      chk($sformatf("rst_ovf_dut%0d", s), get_ovf(s), 0);
      chk($sformatf("rst_addr_dut%0d", s), get_addr(s), 0);
    end

    for (int v = 0; v < NV; v++) begin
      load_scen(vecs[v].sc, vecs[v].sel);
      tall = vecs[v].tl;
      ypos = 9'(vecs[v].yp);
      resetFlags = 1'b1;
      tick();
      resetFlags = 1'b0;
      run_eval(vecs[v].sel, cyc);
      chk($sformatf("v%0d_cycles", v), cyc, vecs[v].cyc);
      chk($sformatf("v%0d_count", v), get_cnt(vecs[v].sel), vecs[v].cnt);
      chk($sformatf("v%0d_zero", v), get_zero(vecs[v].sel), vecs[v].zero);
      chk($sformatf("v%0d_ovf", v), get_ovf(vecs[v].sel), vecs[v].ovf);
      chk($sformatf("v%0d_addr_done", v), get_addr(vecs[v].sel), 0);
      tick();
      chk($sformatf("v%0d_done_pulse", v), get_done(vecs[v].sel), 0);
      chk($sformatf("v%0d_idle", v), get_state(vecs[v].sel), 0);
      chk($sformatf("v%0d_count_hold", v), get_cnt(vecs[v].sel), vecs[v].cnt);
      if (vecs[v].bufk == 1) begin
        for (int i = 0; i < 32; i++) begin
          rd_idx = 6'(i); #1;
          case (i)
            0: chk("buf_y", get_sec(0), 50);
            1: chk("buf_tile", get_sec(0), 8'h12);
            2: chk("buf_attr", get_sec(0), 8'h41);
            3: chk("buf_x", get_sec(0), 8'h80);
            default: chk($sformatf("buf_clear_%0d", i), get_sec(0), 8'hFF);
          endcase
        end
      end else if (vecs[v].bufk == 2) begin
        for (int i = 0; i < 32; i++) begin
          rd_idx = 6'(i); #1;
          chk($sformatf("buf_ff_%0d", i), get_sec(0), 8'hFF);
        end
      end else if (vecs[v].bufk == 3) begin
        rd_idx = 6'd63; #1;
        chk("big_buf_x16", get_sec(2), 8'hAF);
        rd_idx = 6'd60; #1;
        chk("big_buf_y16", get_sec(2), 10);
        rd_idx = 6'd1; #1;
        chk("big_buf_tile1", get_sec(2), 0);
      end
    end

    // Restart while scanning: three copies are complete when the second eval_start lands.
    load_scen(2, 0);
    tall = 1'b0; ypos = 9'd12;
    eval_start[0] = 1'b1;
    tick();
    eval_start = '0;
    repeat (59) tick();
    chk("restart_pre_cnt", get_cnt(0), 3);
    chk("restart_pre_state", get_state(0), 2);
    eval_start[0] = 1'b1;
    tick();
    eval_start = '0;
    chk("restart_cnt", get_cnt(0), 0);
    chk("restart_state", get_state(0), 1);
    chk("restart_busy", get_busy(0), 1);
    wait_done(0, 1, cyc);
    chk("restart_cycles", cyc, 99);
    chk("restart_final_cnt", get_cnt(0), 8);
    chk("restart_final_ovf", get_ovf(0), 1);
    tick();

    // Synchronous reset mid-scan, applied while clock_EN is low.
    eval_start[0] = 1'b1;
    tick();
    eval_start = '0;
    repeat (44) tick();
    chk("rstscan_pre_busy", get_busy(0), 1);
    chk("rstscan_pre_cnt", get_cnt(0), 1);
    chk("rstscan_pre_ovf", get_ovf(0), 1);
    clock_EN = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0; clock_EN = 1'b1;
    chk("rstscan_busy", get_busy(0), 0);
    chk("rstscan_done", get_done(0), 0);
    chk("rstscan_cnt", get_cnt(0), 0);
    chk("rstscan_zero", get_zero(0), 0);
    chk("rstscan_ovf", get_ovf(0), 0);
    chk("rstscan_addr", get_addr(0), 0);
    repeat (3) tick();
    chk("rstscan_stays_idle", get_state(0), 0);

    // Overflow is sticky until resetFlags; count holds meanwhile.
    run_eval(0, cyc);
    tick();
    repeat (5) tick();
    chk("flags_ovf_sticky", get_ovf(0), 1);
    resetFlags = 1'b1;
    tick();
    resetFlags = 1'b0;
    chk("flags_ovf_cleared", get_ovf(0), 0);
    chk("flags_cnt_hold", get_cnt(0), 8);

    // Enable stall: 50 edges in puts n=8 mid-read, oamAddr = 32.
    load_scen(0, 0);
    ypos = 9'd100;
    eval_start[0] = 1'b1;
    tick();
    eval_start = '0;
    repeat (49) tick();
    clock_EN = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("stall_addr_%0d", k), get_addr(0), 32);
      chk($sformatf("stall_state_%0d", k), get_state(0), 2);
    end
    clock_EN = 1'b1;
    wait_done(0, 50, cyc);
    chk("stall_cycles", cyc, 161);
    chk("stall_cnt", get_cnt(0), 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
